// File: rtl/draw_rect_ctl_if.sv
//==============================================================================
// Module      : draw_rect_ctl_if
// Description : Mouse inputs and rectangle position outputs of draw_rect_ctl.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface draw_rect_ctl_if;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        busy;

    modport master (
        output mouse_xpos,
        output mouse_ypos,
        output mouse_left,
        input  xpos,
        input  ypos,
        input  busy
    );

    modport slave (
        input  mouse_xpos,
        input  mouse_ypos,
        input  mouse_left,
        output xpos,
        output ypos,
        output busy
    );
endinterface

`default_nettype wire

// File: rtl/draw_rect_ctl.sv
//==============================================================================
// Module      : draw_rect_ctl
// Description : Rectangle position controller: mouse-follow, gravity drop with
//               damped bounces off the screen bottom, advanced on a divided tick.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module draw_rect_ctl #(
    parameter int TICK_DIV   = 650_000,
    parameter int ACCEL      = 1,
    parameter int VMAX       = 255,
    parameter int MIN_BOUNCE = 4,
    parameter int SCREEN_H   = 600,
    parameter int RECT_H     = 64
) (
    input  wire logic      clk,
    input  wire logic      rst,
    draw_rect_ctl_if.slave bus
);

    localparam int CNT_W = $clog2(TICK_DIV);

    localparam logic [CNT_W-1:0] c_CNT_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [12:0]      c_Y_MAX      = 13'(SCREEN_H - RECT_H);
    localparam logic [8:0]       c_ACCEL      = 9'(ACCEL);
    localparam logic [8:0]       c_VMAX       = 9'(VMAX);
    localparam logic [7:0]       c_MIN_BOUNCE = 8'(MIN_BOUNCE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FALL = 2'd1,
        S_RISE = 2'd2,
        S_STOP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        v_q, v_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [11:0]       xpos_q, xpos_d;
    logic [11:0]       ypos_q, ypos_d;
    logic              busy_q, busy_d;
    logic              left_prev_q;

    logic              press;
    logic              tick;
    logic [8:0]        v_inc;
    logic [7:0]        v_sat;
    logic [12:0]       y_next;
    logic [7:0]        v_bounce;
    logic [8:0]        v_dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            v_q         <= '0;
            cnt_q       <= '0;
            xpos_q      <= '0;
            ypos_q      <= '0;
            busy_q      <= 1'b0;
            // Starts "pressed" so a button held through reset is not a press.
            left_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            cnt_q       <= cnt_d;
            xpos_q      <= xpos_d;
            ypos_q      <= ypos_d;
            busy_q      <= busy_d;
            left_prev_q <= bus.mouse_left;
        end
    end

    always_comb begin
        press    = bus.mouse_left & ~left_prev_q;
        tick     = (cnt_q == c_CNT_LAST);
        v_inc    = {1'b0, v_q} + c_ACCEL;
        v_sat    = (v_inc > c_VMAX) ? c_VMAX[7:0] : v_inc[7:0];
        y_next   = {1'b0, ypos_q} + {5'b0, v_sat};
        v_bounce = v_sat >> 1;
        v_dec    = ({1'b0, v_q} > c_ACCEL) ? ({1'b0, v_q} - c_ACCEL) : 9'd0;

        state_d  = state_q;
        v_d      = v_q;
        xpos_d   = xpos_q;
        ypos_d   = ypos_q;
        cnt_d    = tick ? '0 : cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                xpos_d = bus.mouse_xpos;
                ypos_d = ({1'b0, bus.mouse_ypos} > c_Y_MAX) ? c_Y_MAX[11:0]
                                                            : bus.mouse_ypos;
                if (press) begin
                    state_d = S_FALL;
                    v_d     = '0;
                    cnt_d   = '0;
                end
            end
            S_FALL: begin
                if (tick) begin
                    if (y_next < c_Y_MAX) begin
                        ypos_d = y_next[11:0];
                        v_d    = v_sat;
                    end else begin
                        ypos_d = c_Y_MAX[11:0];
                        if (v_bounce < c_MIN_BOUNCE) begin
                            v_d     = '0;
                            state_d = S_STOP;
                        end else begin
                            v_d     = v_bounce;
                            state_d = S_RISE;
                        end
                    end
                end
            end
            S_RISE: begin
                if (tick) begin
                    ypos_d = (ypos_q > {4'b0, v_q}) ? (ypos_q - {4'b0, v_q}) : 12'd0;
                    v_d    = v_dec[7:0];
                    if (v_dec == 9'd0) begin
                        state_d = S_FALL;
                    end
                end
            end
            S_STOP: begin
                if (press) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_FALL) || (state_d == S_RISE);
    end

    assign bus.xpos = xpos_q;
    assign bus.ypos = ypos_q;
    assign bus.busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_draw_rect_ctl.sv
//==============================================================================
// Module      : tb_draw_rect_ctl
// Description : Self-checking bench for draw_rect_ctl against a trajectory model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_draw_rect_ctl;

    localparam int TICK_DIV   = 4;
    localparam int ACCEL      = 1;
    localparam int VMAX       = 255;
    localparam int MIN_BOUNCE = 4;
    localparam int Y_MAX      = 600 - 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    draw_rect_ctl_if bus ();

    draw_rect_ctl #(
        .TICK_DIV   (TICK_DIV),
        .ACCEL      (ACCEL),
        .VMAX       (VMAX),
        .MIN_BOUNCE (MIN_BOUNCE),
        .SCREEN_H   (600),
        .RECT_H     (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int y;
        bit busy;
    } pt_t;

    pt_t traj[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Position/busy after every motion tick of one drop, from its starting height.
    task automatic build_traj(input int y0);
        int  y;
        int  v;
        int  vn;
        int  b;
        bit  rising;
        pt_t p;
        traj.delete();
        y      = y0;
        v      = 0;
        rising = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            if (!rising) begin
                vn = (v + ACCEL > VMAX) ? VMAX : v + ACCEL;
                if (y + vn < Y_MAX) begin
                    y = y + vn;
                    v = vn;
                end else begin
                    y = Y_MAX;
                    b = vn / 2;
                    if (b < MIN_BOUNCE) begin
                        p.y = y; p.busy = 1'b0; traj.push_back(p);
                        return;
                    end
                    v      = b;
                    rising = 1'b1;
                end
            end else begin
                y = (y > v) ? y - v : 0;
                v = (v > ACCEL) ? v - ACCEL : 0;
                if (v == 0) rising = 1'b0;
            end
            p.y = y; p.busy = 1'b1; traj.push_back(p);
        end
    endtask

    task automatic press();
        bus.mouse_left = 1'b0;
        step();
        bus.mouse_left = 1'b1;
        step();
    endtask

    task automatic run_traj(input int max_ticks, input bit poke);
        int x0;
        int prev_y;
        x0     = int'(bus.xpos);
        prev_y = int'(bus.ypos);
        for (int i = 0; i < traj.size() && i < max_ticks; i++) begin
            for (int j = 0; j < TICK_DIV - 1; j++) begin
                bus.mouse_xpos = 12'($urandom_range(0, 4095));
                if (poke && i == 2) bus.mouse_left = (j == 1);
                step();
            end
            chk("hold_between_ticks", bus.ypos, prev_y);
            step();
            chk("tick_ypos", bus.ypos, traj[i].y);
            chk("tick_busy", bus.busy, traj[i].busy);
            chk("xpos_frozen", bus.xpos, x0);
            prev_y = traj[i].y;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int x;
        int y;

        // Reset with the button held down.
        bus.mouse_xpos = 12'd50;
        bus.mouse_ypos = 12'd60;
        bus.mouse_left = 1'b1;
        rst = 1'b1;
        step();
        step();
        chk("rst_xpos", bus.xpos, 0);
        chk("rst_ypos", bus.ypos, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("held_no_fall", bus.busy, 0);
        end
        chk("held_follow_x", bus.xpos, 50);
        chk("held_follow_y", bus.ypos, 60);

        // Mouse follow, including the floor clamp.
        bus.mouse_xpos = 12'd100;
        bus.mouse_ypos = 12'd200;
        step();
        chk("follow_x", bus.xpos, 100);
        chk("follow_y", bus.ypos, 200);
        bus.mouse_ypos = 12'd590;
        step();
        chk("follow_clamp_y", bus.ypos, Y_MAX);
        for (int i = 0; i < 10; i++) begin
            x = $urandom_range(0, 4095);
            y = $urandom_range(0, 4095);
            bus.mouse_xpos = 12'(x);
            bus.mouse_ypos = 12'(y);
            step();
            chk("rand_follow_x", bus.xpos, x);
            chk("rand_follow_y", bus.ypos, (y > Y_MAX) ? Y_MAX : y);
        end

        // Short drop from 530: two falling ticks then straight to STOP.
        bus.mouse_xpos = 12'd300;
        bus.mouse_ypos = 12'd530;
        press();
        chk("short_start_busy", bus.busy, 1);
        chk("short_start_y", bus.ypos, 530);
        chk("short_start_x", bus.xpos, 300);
        build_traj(530);
        run_traj(1000, 1'b0);

        // Press in STOP returns to follow one clk later.
        bus.mouse_xpos = 12'd777;
        bus.mouse_ypos = 12'd100;
        press();
        chk("stop_press_x_held", bus.xpos, 300);
        chk("stop_press_y_held", bus.ypos, Y_MAX);
        step();
        chk("resume_follow_x", bus.xpos, 777);
        chk("resume_follow_y", bus.ypos, 100);

        // Full drop from the top with a press injected during the fall.
        bus.mouse_xpos = 12'd400;
        bus.mouse_ypos = 12'd0;
        press();
        build_traj(0);
        run_traj(10000, 1'b1);
        chk("settle_y", bus.ypos, Y_MAX);
        chk("settle_busy", bus.busy, 0);
        bus.mouse_xpos = 12'd11;
        bus.mouse_ypos = 12'd22;
        press();
        step();
        chk("settle_follow_x", bus.xpos, 11);
        chk("settle_follow_y", bus.ypos, 22);

        // Reset on the first rising tick.
        bus.mouse_xpos = 12'd123;
        bus.mouse_ypos = 12'd0;
        press();
        build_traj(0);
        run_traj(34, 1'b0);
        chk("rise_busy", bus.busy, 1);
        bus.mouse_left = 1'b0;
        rst = 1'b1;
        step();
        chk("midrise_rst_x", bus.xpos, 0);
        chk("midrise_rst_y", bus.ypos, 0);
        chk("midrise_rst_busy", bus.busy, 0);
        rst = 1'b0;
        bus.mouse_xpos = 12'd222;
        bus.mouse_ypos = 12'd333;
        step();
        chk("post_rst_follow_x", bus.xpos, 222);
        chk("post_rst_follow_y", bus.ypos, 333);

        // Randomized drops from arbitrary heights.
        for (int k = 0; k < 4; k++) begin
            x = $urandom_range(0, 4095);
            y = $urandom_range(0, 700);
            bus.mouse_xpos = 12'(x);
            bus.mouse_ypos = 12'(y);
            press();
            chk("rand_drop_x", bus.xpos, x);
            build_traj((y > Y_MAX) ? Y_MAX : y);
            run_traj(10000, 1'b0);
            chk("rand_drop_end_y", bus.ypos, Y_MAX);
            bus.mouse_xpos = 12'd5;
            bus.mouse_ypos = 12'd6;
            press();
            step();
            chk("rand_drop_follow_y", bus.ypos, 6);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
